// File: rtl/lcd_rgb_rx.sv
// lcd_rgb_rx: receiver for a DE-only parallel RGB666 stream (no HS/VS).
// Frame and line boundaries are recovered from DE activity alone. A DE-low
// run of VBLANK_MIN cycles is treated as vertical blank; any shorter gap is
// a horizontal blank. The pixel path has a fixed 2-cycle latency.
//
// Ports
//   lcd_clk, rst         pixel clock, synchronous active-high reset
//   lcd_en, lcd_r/g/b    incoming data enable and 6-bit colour components
//   pix_valid/pix_data   framed pixel stream, data = {r,g,b}, held when idle
//   pix_sof, pix_eol     first pixel of frame, last pixel of each line
//   frame_done           pulse when vertical blank follows a frame
//   h_meas, v_meas       last line length, last frame line count
//   line_err             pulse at a line end whose length != H_ACTIVE
//   locked               LOCK_FRAMES consecutive frames matched geometry
module lcd_rgb_rx #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter int VBLANK_MIN  = 1000,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        lcd_clk,
  input  logic        rst,
  input  logic        lcd_en,
  input  logic [5:0]  lcd_r,
  input  logic [5:0]  lcd_g,
  input  logic [5:0]  lcd_b,
  output logic        pix_valid,
  output logic [17:0] pix_data,
  output logic        pix_sof,
  output logic        pix_eol,
  output logic        frame_done,
  output logic [11:0] h_meas,
  output logic [10:0] v_meas,
  output logic        line_err,
  output logic        locked
);

  localparam int IW = $clog2(VBLANK_MIN + 1);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(VBLANK_MIN);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_WAIT, S_ARMED, S_ACTIVE} state_e;

  function automatic logic [11:0] sat_x(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  function automatic logic [10:0] sat_y(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [IW-1:0] sat_idle(input logic [IW-1:0] v);
    return (v == IDLE_MAX) ? v : v + IW'(1);
  endfunction

  function automatic logic [GW-1:0] sat_good(input logic [GW-1:0] v);
    return (v == GOOD_MAX) ? v : v + GW'(1);
  endfunction

  state_e          state_q, state_d;
  logic            vld_p0, vld_p1;
  logic [17:0]     rgb_p0;
  logic [IW-1:0]   idle_q, idle_d;
  logic [11:0]     x_q, x_d;
  logic [10:0]     y_q, y_d;
  logic [GW-1:0]   good_q, good_d;
  logic            err_seen_q;
  logic            fall, vblank_hit, start, frame_good;
  logic            valid_d, sof_d, eol_d, fd_d, lerr_d;

  // Stage p0: input capture. Data is not reset; only the enable is.
  always_ff @(posedge lcd_clk) begin
    rgb_p0 <= {lcd_r, lcd_g, lcd_b};
  end

  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p0 <= lcd_en;
      vld_p1 <= vld_p0;
    end
  end

  // DE edge / blank detection on the p0 stream. vld_p1 is the previous p0
  // sample, so fall marks the first low cycle after a line.
  always_comb begin
    fall       = vld_p1 & ~vld_p0;
    idle_d     = vld_p0 ? '0 : sat_idle(idle_q);
    vblank_hit = (idle_d == IDLE_MAX);
    x_d        = vld_p0 ? sat_x(x_q) : 12'd0;
    start      = (state_q == S_ARMED) & vld_p0;
    if (start)     y_d = 11'd0;
    else if (fall) y_d = sat_y(y_q);
    else           y_d = y_q;
  end

  // State register
  always_ff @(posedge lcd_clk) begin
    if (rst) state_q <= S_WAIT;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:   if (vblank_hit) state_d = S_ARMED;
      S_ARMED:  if (vld_p0)     state_d = S_ACTIVE;
      S_ACTIVE: if (vblank_hit) state_d = S_ARMED;
      default:                  state_d = S_WAIT;
    endcase
  end

  // Output logic. eol looks one sample ahead: the live input is the cycle
  // after the pixel held in p0.
  always_comb begin
    valid_d    = vld_p0 & (state_q != S_WAIT);
    sof_d      = start;
    eol_d      = valid_d & ~lcd_en;
    fd_d       = (state_q == S_ACTIVE) & vblank_hit;
    lerr_d     = (state_q == S_ACTIVE) & fall & (x_q != 12'(H_ACTIVE));
    frame_good = (y_q == 11'(V_ACTIVE)) & ~err_seen_q;
    good_d     = frame_good ? sat_good(good_q) : '0;
  end

  // Stage p1: registered outputs and measurement state
  always_ff @(posedge lcd_clk) begin
    if (rst) begin
      idle_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      good_q     <= '0;
      err_seen_q <= 1'b0;
      pix_valid  <= 1'b0;
      pix_data   <= '0;
      pix_sof    <= 1'b0;
      pix_eol    <= 1'b0;
      frame_done <= 1'b0;
      h_meas     <= '0;
      v_meas     <= '0;
      line_err   <= 1'b0;
      locked     <= 1'b0;
    end else begin
      idle_q     <= idle_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pix_valid  <= valid_d;
      pix_sof    <= sof_d;
      pix_eol    <= eol_d;
      frame_done <= fd_d;
      line_err   <= lerr_d;
      if (valid_d) pix_data <= rgb_p0;
      if (fall)    h_meas   <= x_q;
      if (start)       err_seen_q <= 1'b0;
      else if (lerr_d) err_seen_q <= 1'b1;
      if (fd_d) begin
        v_meas <= y_q;
        good_q <= good_d;
        locked <= frame_good & (good_d == GOOD_MAX);
      end
    end
  end

endmodule

// File: tb/tb_lcd_rgb_rx.sv
module tb_lcd_rgb_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        lcd_en;
  logic [5:0]  lcd_r, lcd_g, lcd_b;
  logic        pix_valid, pix_sof, pix_eol, frame_done, line_err, locked;
  logic [17:0] pix_data;
  logic [11:0] h_meas;
  logic [10:0] v_meas;

  always #5 clk = ~clk;

  lcd_rgb_rx #(
    .H_ACTIVE(8), .V_ACTIVE(4), .VBLANK_MIN(16), .LOCK_FRAMES(2)
  ) dut (
    .lcd_clk(clk), .rst(rst), .lcd_en(lcd_en),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof),
    .pix_eol(pix_eol), .frame_done(frame_done), .h_meas(h_meas),
    .v_meas(v_meas), .line_err(line_err), .locked(locked)
  );

  int          checks = 0;
  int          errors = 0;
  int          n_valid, n_sof, n_eol, n_fd, n_lerr, n_sve;
  logic [11:0] le_h;
  logic [10:0] fd_v;
  logic        first_sof, seen_valid, prev_valid;
  logic [17:0] d1, d2;
  logic [17:0] pix_ctr = 18'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    n_valid = 0; n_sof = 0; n_eol = 0; n_fd = 0; n_lerr = 0; n_sve = 0;
    le_h = '0; fd_v = '0; first_sof = 1'b0; seen_valid = 1'b0;
  endtask

  // One clock: sample outputs 1 ns after the edge, then drive the next input.
  task automatic tick(input logic en, input logic [17:0] rgb);
    @(posedge clk); #1;
    if (pix_valid === 1'b1) begin
      n_valid++;
      chk("pix_data", {14'd0, pix_data}, {14'd0, d2});
      if (!seen_valid) begin seen_valid = 1'b1; first_sof = pix_sof; end
    end
    if (pix_sof === 1'b1) n_sof++;
    if (pix_eol === 1'b1) n_eol++;
    if (pix_valid === 1'b1 && pix_eol === 1'b1 && pix_sof === 1'b1 && prev_valid !== 1'b1) n_sve++;
    prev_valid = pix_valid;
    if (frame_done === 1'b1) begin n_fd++; fd_v = v_meas; end
    if (line_err === 1'b1) begin n_lerr++; le_h = h_meas; end
    lcd_en = en;
    {lcd_r, lcd_g, lcd_b} = rgb;
    d2 = d1;
    d1 = rgb;
  endtask

  task automatic hi(input int k);
    for (int i = 0; i < k; i++) begin
      tick(1'b1, pix_ctr);
      pix_ctr = pix_ctr + 18'd1;
    end
  endtask

  task automatic lo(input int k);
    for (int i = 0; i < k; i++) tick(1'b0, 18'h3FFFF);
  endtask

  // nlines lines of 8 pixels (line short_line gets short_len), 4-cycle
  // horizontal gaps, then 20 more low cycles of vertical blank.
  task automatic frame(input int nlines, input int short_line, input int short_len);
    for (int l = 0; l < nlines; l++) begin
      hi((l == short_line) ? short_len : 8);
      lo(4);
    end
    lo(20);
  endtask

  task automatic chk_clean(input string tag, input logic exp_locked);
    chk({tag, "_valid"}, n_valid, 32);
    chk({tag, "_sof"}, n_sof, 1);
    chk({tag, "_eol"}, n_eol, 4);
    chk({tag, "_fd"}, n_fd, 1);
    chk({tag, "_vmeas"}, {21'd0, fd_v}, 4);
    chk({tag, "_hmeas"}, {20'd0, h_meas}, 8);
    chk({tag, "_lerr"}, n_lerr, 0);
    chk({tag, "_locked"}, {31'd0, locked}, {31'd0, exp_locked});
  endtask

  initial begin
    rst = 1'b1; lcd_en = 1'b0; lcd_r = '0; lcd_g = '0; lcd_b = '0;
    d1 = '0; d2 = '0; prev_valid = 1'b0;
    clr();
    lo(3);
    chk("rst_valid", {31'd0, pix_valid}, 0);
    chk("rst_sof", {31'd0, pix_sof}, 0);
    chk("rst_eol", {31'd0, pix_eol}, 0);
    chk("rst_fd", {31'd0, frame_done}, 0);
    chk("rst_lerr", {31'd0, line_err}, 0);
    chk("rst_locked", {31'd0, locked}, 0);
    chk("rst_hmeas", {20'd0, h_meas}, 0);
    chk("rst_vmeas", {21'd0, v_meas}, 0);
    chk("rst_data", {14'd0, pix_data}, 0);
    rst = 1'b0;

    // Frame with no preceding vblank is suppressed.
    clr(); lo(1); frame(4, -1, 0);
    chk("f1_valid", n_valid, 0);
    chk("f1_fd", n_fd, 0);

    clr(); frame(4, -1, 0); chk_clean("f2", 1'b0);
    clr(); frame(4, -1, 0); chk_clean("f3", 1'b1);

    // Shortened line breaks lock; two clean frames restore it.
    clr(); frame(4, 1, 7);
    chk("short_lerr", n_lerr, 1);
    chk("short_h", {20'd0, le_h}, 7);
    chk("short_valid", n_valid, 31);
    chk("short_fd", n_fd, 1);
    chk("short_locked", {31'd0, locked}, 0);
    clr(); frame(4, -1, 0); chk_clean("rl1", 1'b0);
    clr(); frame(4, -1, 0); chk_clean("rl2", 1'b1);

    // Five-line frame.
    clr(); frame(5, -1, 0);
    chk("v5_fd", n_fd, 1);
    chk("v5_vmeas", {21'd0, fd_v}, 5);
    chk("v5_lerr", n_lerr, 0);
    chk("v5_locked", {31'd0, locked}, 0);

    // Single-pixel first line.
    clr(); frame(4, 0, 1);
    chk("px1_sve", n_sve, 1);
    chk("px1_lerr", n_lerr, 1);
    chk("px1_h", {20'd0, le_h}, 1);
    chk("px1_valid", n_valid, 25);

    // Reset mid-line, released mid-line.
    hi(3);
    rst = 1'b1; hi(2); rst = 1'b0;
    clr();
    hi(3); lo(4);
    for (int l = 0; l < 3; l++) begin hi(8); lo(4); end
    lo(20);
    chk("mrst_valid", n_valid, 0);
    chk("mrst_fd", n_fd, 0);
    clr(); frame(4, -1, 0);
    chk("mrst_first_sof", {31'd0, first_sof}, 1);
    chk_clean("mrst", 1'b0);

    // DE stuck high.
    clr(); hi(5000);
    chk("stuck_fd", n_fd, 0);
    lo(20);
    chk("stuck_h", {20'd0, h_meas}, 4095);
    chk("stuck_lerr", n_lerr, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
